// File: rtl/ddr_fifo_model_if.sv
// Purpose: user-side FIFO bus between the DDR3 test generator/checker and the memory model.
// Ports:   write stream (wr_en/wr_data), replay request (rd_req), read return (rd_data/rd_valid),
//          fill status (wr_full/rd_empty/wr_count), sticky error flags and calibration status.
interface ddr_fifo_model_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic              init_calib_complete;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_full;
    logic              rd_empty;
    logic [ADDR_W:0]   wr_count;
    logic              overflow;
    logic              underflow;

    // master: traffic generator side
    modport master (
        output wr_en, wr_data, rd_req,
        input  init_calib_complete, rd_data, rd_valid, wr_full, rd_empty,
               wr_count, overflow, underflow
    );

    // slave: memory model side
    modport slave (
        input  wr_en, wr_data, rd_req,
        output init_calib_complete, rd_data, rd_valid, wr_full, rd_empty,
               wr_count, overflow, underflow
    );
endinterface

// File: rtl/ddr_fifo_model.sv
// Purpose: behavioural DDR3 stand-in; after a calibration delay it buffers the write stream
//          and replays the stored words in a loop while rd_req is held (reads do not consume).
// Ports:   clk_50m, rst (sync, active-high), bus (slave side of ddr_fifo_model_if).
//          Read latency 1 cycle; writes while full are dropped and flagged, never back-pressured.
module ddr_fifo_model #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 1024,
    parameter int CALIB_CYCLES = 200
) (
    input logic              clk_50m,
    input logic              rst,
    ddr_fifo_model_if.slave  bus
);

    typedef enum logic {
        CALIB = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [15:0]   CALIB_END = 16'(CALIB_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    state_t              state;
    state_t              state_nxt;
    logic [15:0]         calib_cnt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     wr_count;
    logic [ADDR_W:0]     cnt_last;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                overflow;
    logic                underflow;
    logic                full;
    logic                empty;

    logic                calib_done;
    logic                wr_acc;
    logic                wr_drop;
    logic                rd_hit;
    logic                rd_miss;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign full     = (wr_count == DEPTH_CNT);
    assign empty    = (wr_count == '0);
    assign cnt_last = wr_count - CNT_ONE;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state <= CALIB;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (state == CALIB && calib_cnt == CALIB_END) begin
            state_nxt = READY;
        end
    end

    // ---------------- FSM: outputs / request qualification ----------------
    always_comb begin
        calib_done = (state == READY);
        wr_acc     = calib_done && bus.wr_en && !full;
        wr_drop    = calib_done && bus.wr_en && full;
        rd_hit     = calib_done && bus.rd_req && !empty;
        rd_miss    = calib_done && bus.rd_req && empty;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            calib_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_count  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (state == CALIB) begin
                calib_cnt <= calib_cnt + 16'd1;
            end

            if (wr_acc) begin
                wr_ptr   <= wr_ptr + ADDR_W'(1);
                wr_count <= wr_count + CNT_ONE;
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end

            rd_valid <= rd_hit;
            if (rd_hit) begin
                rd_data <= mem[rd_ptr];
                // Wrap against the pre-write count: a word written this cycle
                // only joins the loop at the next wrap decision.
                if ({1'b0, rd_ptr} == cnt_last) begin
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end
            if (rd_miss) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is never reset; only wr_count defines what is valid. The read
    // address is always below the pre-write count, so it never collides with
    // the slot being written.
    always_ff @(posedge clk_50m) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.init_calib_complete = calib_done;
    assign bus.rd_data             = rd_data;
    assign bus.rd_valid            = rd_valid;
    assign bus.wr_full             = full;
    assign bus.rd_empty            = empty;
    assign bus.wr_count            = wr_count;
    assign bus.overflow            = overflow;
    assign bus.underflow           = underflow;

endmodule

// File: tb/tb_ddr_fifo_model.sv
// Purpose: self-checking bench for ddr_fifo_model; directed scenarios plus random traffic,
//          every cycle compared against a queue-based reference model.
// Ports:   none (top level); drives the master side of ddr_fifo_model_if.
module tb_ddr_fifo_model;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 10;
    localparam int DEPTH        = 1024;
    localparam int CALIB_CYCLES = 200;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;

    always #5 clk_50m = ~clk_50m;

    ddr_fifo_model_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ddr_fifo_model #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .CALIB_CYCLES (CALIB_CYCLES)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: cycles since reset, the stored words as a queue, and a
    // replay index taken modulo the number of stored words.
    int m_cyc = 0;
    int m_q[$];
    int m_idx = 0;
    int m_data = 0;
    bit m_vld = 0;
    bit m_ov  = 0;
    bit m_un  = 0;

    task automatic model_edge();
        bit ready;
        if (rst) begin
            m_cyc = 0;
            m_q.delete();
            m_idx  = 0;
            m_data = 0;
            m_vld  = 0;
            m_ov   = 0;
            m_un   = 0;
        end else begin
            ready = (m_cyc >= CALIB_CYCLES);
            if (m_cyc < CALIB_CYCLES) m_cyc++;
            if (ready) begin
                m_vld = 0;
                if (bus.rd_req) begin
                    if (m_q.size() != 0) begin
                        m_data = m_q[m_idx];
                        m_vld  = 1;
                        m_idx  = (m_idx + 1) % m_q.size();
                    end else begin
                        m_un = 1;
                    end
                end
                if (bus.wr_en) begin
                    if (m_q.size() < DEPTH) m_q.push_back(int'(bus.wr_data));
                    else m_ov = 1;
                end
            end
        end
    endtask

    // One clock: model follows the inputs sampled at the rising edge, the DUT
    // is compared on the falling edge, and new inputs are then driven.
    task automatic tick();
        logic [15:0] exp_data;
        @(posedge clk_50m);
        model_edge();
        @(negedge clk_50m);
        exp_data = m_data[15:0];
        chk("init_calib_complete", 32'(bus.init_calib_complete), 32'(m_cyc >= CALIB_CYCLES));
        chk("rd_valid",  32'(bus.rd_valid),  32'(m_vld));
        chk("rd_data",   32'(bus.rd_data),   32'(exp_data));
        chk("wr_count",  32'(bus.wr_count),  32'(m_q.size()));
        chk("wr_full",   32'(bus.wr_full),   32'(m_q.size() == DEPTH));
        chk("rd_empty",  32'(bus.rd_empty),  32'(m_q.size() == 0));
        chk("overflow",  32'(bus.overflow),  32'(m_ov));
        chk("underflow", 32'(bus.underflow), 32'(m_un));
    endtask

    task automatic reset_and_calib();
        rst = 1'b1;
        bus.wr_en  = 1'b0;
        bus.rd_req = 1'b0;
        tick();
        rst = 1'b0;
        repeat (CALIB_CYCLES) tick();
    endtask

    int cc_exp[7] = '{10, 11, 12, 13, 14, 15, 10};

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_req  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_rd_empty", 32'(bus.rd_empty), 32'd1);
        chk("reset_init", 32'(bus.init_calib_complete), 32'd0);

        // Calibration, with a write pulse that must be ignored at edge 100
        rst = 1'b0;
        for (int i = 1; i <= CALIB_CYCLES; i++) begin
            bus.wr_en   = (i == 100);
            bus.wr_data = 16'h1234;
            tick();
            if (i == CALIB_CYCLES - 1) chk("calib_edge199", 32'(bus.init_calib_complete), 32'd0);
            if (i == CALIB_CYCLES)     chk("calib_edge200", 32'(bus.init_calib_complete), 32'd1);
        end
        chk("calib_write_ignored", 32'(bus.wr_count), 32'd0);
        bus.wr_en = 1'b0;

        // Fill 1..1024
        for (int i = 1; i <= DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(i);
            tick();
        end
        chk("fill_full", 32'(bus.wr_full), 32'd1);
        chk("fill_count", 32'(bus.wr_count), 32'd1024);

        // Overflow: extra word is dropped
        bus.wr_data = 16'hBEEF;
        tick();
        bus.wr_en = 1'b0;
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.wr_count), 32'd1024);

        // Replay for 2100 cycles: 1..1024, 1..1024, 1..52
        for (int k = 0; k < 2100; k++) begin
            bus.rd_req = 1'b1;
            tick();
            chk("replay_seq", 32'(bus.rd_data), 32'((k % DEPTH) + 1));
            chk("replay_vld", 32'(bus.rd_valid), 32'd1);
        end
        chk("replay_no_underflow", 32'(bus.underflow), 32'd0);

        // Mid-operation reset during replay
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_empty", 32'(bus.rd_empty), 32'd1);
        chk("midrst_init", 32'(bus.init_calib_complete), 32'd0);
        chk("midrst_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 1; i <= CALIB_CYCLES; i++) begin
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_data = 16'($urandom);
            bus.rd_req  = 1'($urandom_range(0, 1));
            tick();
            if (i == CALIB_CYCLES - 1) chk("recal_edge199", 32'(bus.init_calib_complete), 32'd0);
            if (i == CALIB_CYCLES)     chk("recal_edge200", 32'(bus.init_calib_complete), 32'd1);
        end
        chk("recal_nothing_stored", 32'(bus.wr_count), 32'd0);

        // Underflow on empty buffer
        bus.wr_en  = 1'b0;
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        chk("unf_flag", 32'(bus.underflow), 32'd1);
        chk("unf_vld", 32'(bus.rd_valid), 32'd0);
        chk("unf_data", 32'(bus.rd_data), 32'd0);

        // Concurrent read and write. The write of 15 lands with the read of 13,
        // so the wrap decision at 14 already sees six words.
        reset_and_calib();
        for (int i = 10; i <= 14; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        for (int j = 0; j < 7; j++) begin
            bus.rd_req  = 1'b1;
            bus.wr_en   = (j == 3);
            bus.wr_data = 16'd15;
            tick();
            chk("concurrent_seq", 32'(bus.rd_data), 32'(cc_exp[j]));
        end
        bus.wr_en  = 1'b0;
        bus.rd_req = 1'b0;

        // Random traffic against the model, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 799) == 0);
            bus.wr_en   = ($urandom_range(0, 3) != 0);
            bus.wr_data = 16'($urandom);
            bus.rd_req  = 1'($urandom_range(0, 1));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
